instruction_decode_stage: RTL and testbench

//   RV32I decode stage between fetch and execute. Holds the IF/ID pipeline register and decodes the held instruction.

---
 rtl/instruction_decode_stage_pkg.sv | 47 ++++
 rtl/instruction_decode_stage_imm_gen.sv | 34 +++
 rtl/instruction_decode_stage.sv | 161 ++++++++++++++++
 tb/tb_instruction_decode_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_stage_pkg.sv
// Shared RV32I decode definitions: opcode values, the canonical NOP and a
// per-opcode property table used by the decode stage and its immediate generator.
package instruction_decode_stage_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // addi x0,x0,0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic legal;
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic mem_read;
    } op_info_t;

    // Unknown opcodes keep uses_rs1 set so a hazard on them is still resolved
    // conservatively, but never write rd or read memory.
    function automatic op_info_t decode_opcode(input logic [6:0] opcode);
        op_info_t info;
        info = '{legal: 1'b1, uses_rs1: 1'b1, uses_rs2: 1'b0,
                 writes_rd: 1'b0, mem_read: 1'b0};
        case (opcode)
            OP_R:      begin info.uses_rs2 = 1'b1; info.writes_rd = 1'b1; end
            OP_IMM:    info.writes_rd = 1'b1;
            OP_LOAD:   begin info.writes_rd = 1'b1; info.mem_read = 1'b1; end
            OP_STORE:  info.uses_rs2 = 1'b1;
            OP_BRANCH: info.uses_rs2 = 1'b1;
            OP_JAL:    begin info.uses_rs1 = 1'b0; info.writes_rd = 1'b1; end
            OP_JALR:   info.writes_rd = 1'b1;
            OP_LUI,
            OP_AUIPC:  begin info.uses_rs1 = 1'b0; info.writes_rd = 1'b1; end
            default:   info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/instruction_decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: selects the I/S/B/U/J layout from
// the opcode and sign-extends from instr[31]; R-type and unknown opcodes give 0.
module imm_gen
    import instruction_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic sign;
    assign sign = instr[31];

    always_comb begin
        // NOTE: default first so every path assigns imm and no latch is inferred.
        imm = '0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                imm = {{(XLEN-11){sign}}, instr[30:20]};
            OP_STORE:
                imm = {{(XLEN-11){sign}}, instr[30:25], instr[11:7]};
            OP_BRANCH:
                imm = {{(XLEN-12){sign}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {{(XLEN-31){sign}}, instr[30:12], 12'b0};
            OP_JAL:
                imm = {{(XLEN-20){sign}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: IF/ID register, operand fetch with write-back forwarding,
// load-use hazard detection and the ID/EX pipeline register.
module instruction_decode_stage
    import instruction_decode_stage_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = RV_NOP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ifValid,
    input  logic [31:0]     ifInstr,
    input  logic [XLEN-1:0] ifPc,
    input  logic            flush,
    output logic            stall,
    output logic [4:0]      readRegister1,
    output logic [4:0]      readRegister2,
    input  logic [XLEN-1:0] readData1,
    input  logic [XLEN-1:0] readData2,
    input  logic            wbRegWrite,
    input  logic [4:0]      wbRd,
    input  logic [XLEN-1:0] wbData,
    output logic            exValid,
    output logic [XLEN-1:0] exPc,
    output logic [XLEN-1:0] exRs1Data,
    output logic [XLEN-1:0] exRs2Data,
    output logic [XLEN-1:0] exImm,
    output logic [4:0]      exRs1,
    output logic [4:0]      exRs2,
    output logic [4:0]      exRd,
    output logic [6:0]      exOpcode,
    output logic [2:0]      exFunct3,
    output logic            exFunct7b5,
    output logic            exMemRead,
    output logic            exRegWrite,
    output logic            exIllegal
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            mem_read;
        logic            reg_write;
        logic            illegal;
    } id_ex_t;

    logic            id_valid;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= '0;
        end else if (!stall) begin
            id_valid <= ifValid;
            id_instr <= ifInstr;
            id_pc    <= ifPc;
        end
    end

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    op_info_t        info;
    logic [XLEN-1:0] imm;

    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign rd     = id_instr[11:7];
    assign opcode = id_instr[6:0];
    assign info   = decode_opcode(opcode);

    assign readRegister1 = rs1;
    assign readRegister2 = rs2;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (id_instr),
        .imm   (imm)
    );

    // The bubble this inserts clears exMemRead, so the stall self-releases after one cycle.
    assign stall = id_valid && exValid && exMemRead && (exRd != 5'd0) &&
                   (((exRd == rs1) && info.uses_rs1) || ((exRd == rs2) && info.uses_rs2));

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    always_comb begin
        rs1_data = readData1;
        rs2_data = readData2;
        if (rs1 == 5'd0)
            rs1_data = '0;
        else if (wbRegWrite && (wbRd == rs1))
            rs1_data = wbData;
        if (rs2 == 5'd0)
            rs2_data = '0;
        else if (wbRegWrite && (wbRd == rs2))
            rs2_data = wbData;
    end

    id_ex_t id_ex_d;
    id_ex_t id_ex_q;

    always_comb begin
        id_ex_d           = '0;
        id_ex_d.valid     = 1'b1;
        id_ex_d.pc        = id_pc;
        id_ex_d.rs1_data  = rs1_data;
        id_ex_d.rs2_data  = rs2_data;
        id_ex_d.imm       = imm;
        id_ex_d.rs1       = rs1;
        id_ex_d.rs2       = rs2;
        id_ex_d.rd        = rd;
        id_ex_d.opcode    = opcode;
        id_ex_d.funct3    = id_instr[14:12];
        id_ex_d.funct7b5  = id_instr[30];
        id_ex_d.mem_read  = info.mem_read;
        id_ex_d.reg_write = info.writes_rd && (rd != 5'd0);
        id_ex_d.illegal   = !info.legal;
    end

    always_ff @(posedge clk) begin
        if (reset || flush || stall || !id_valid)
            id_ex_q <= '0;
        else
            id_ex_q <= id_ex_d;
    end

    assign exValid    = id_ex_q.valid;
    assign exPc       = id_ex_q.pc;
    assign exRs1Data  = id_ex_q.rs1_data;
    assign exRs2Data  = id_ex_q.rs2_data;
    assign exImm      = id_ex_q.imm;
    assign exRs1      = id_ex_q.rs1;
    assign exRs2      = id_ex_q.rs2;
    assign exRd       = id_ex_q.rd;
    assign exOpcode   = id_ex_q.opcode;
    assign exFunct3   = id_ex_q.funct3;
    assign exFunct7b5 = id_ex_q.funct7b5;
    assign exMemRead  = id_ex_q.mem_read;
    assign exRegWrite = id_ex_q.reg_write;
    assign exIllegal  = id_ex_q.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed self-checking bench for instruction_decode_stage: reset, latency,
// load-use stall, forwarding, immediates, flush, illegal opcodes and bubbles.
module tb_instruction_decode_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            ifValid;
    logic [31:0]     ifInstr;
    logic [XLEN-1:0] ifPc;
    logic            flush;
    logic            stall;
    logic [4:0]      readRegister1;
    logic [4:0]      readRegister2;
    logic [XLEN-1:0] readData1;
    logic [XLEN-1:0] readData2;
    logic            wbRegWrite;
    logic [4:0]      wbRd;
    logic [XLEN-1:0] wbData;
    logic            exValid;
    logic [XLEN-1:0] exPc;
    logic [XLEN-1:0] exRs1Data;
    logic [XLEN-1:0] exRs2Data;
    logic [XLEN-1:0] exImm;
    logic [4:0]      exRs1;
    logic [4:0]      exRs2;
    logic [4:0]      exRd;
    logic [6:0]      exOpcode;
    logic [2:0]      exFunct3;
    logic            exFunct7b5;
    logic            exMemRead;
    logic            exRegWrite;
    logic            exIllegal;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] I_ADDI_X5_7 = 32'h0070_0293;
    localparam logic [31:0] I_LW_X6     = 32'h0002_A303;  // lw  x6,0(x5)
    localparam logic [31:0] I_ADD_X7    = 32'h0013_03B3;  // add x7,x6,x1
    localparam logic [31:0] I_SUB_X4    = 32'h4031_8233;  // sub x4,x3,x3

    instruction_decode_stage #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .ifValid       (ifValid),
        .ifInstr       (ifInstr),
        .ifPc          (ifPc),
        .flush         (flush),
        .stall         (stall),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .readData1     (readData1),
        .readData2     (readData2),
        .wbRegWrite    (wbRegWrite),
        .wbRd          (wbRd),
        .wbData        (wbData),
        .exValid       (exValid),
        .exPc          (exPc),
        .exRs1Data     (exRs1Data),
        .exRs2Data     (exRs2Data),
        .exImm         (exImm),
        .exRs1         (exRs1),
        .exRs2         (exRs2),
        .exRd          (exRd),
        .exOpcode      (exOpcode),
        .exFunct3      (exFunct3),
        .exFunct7b5    (exFunct7b5),
        .exMemRead     (exMemRead),
        .exRegWrite    (exRegWrite),
        .exIllegal     (exIllegal)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (exValid !== 1'b0) begin n_err++; $display("FAIL reset_exValid: got %0h want 0", exValid); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0h want 0", stall); end
        n_cmp++; if ({exPc, exImm, exRd, exOpcode, exRegWrite, exMemRead, exIllegal} !== '0) begin
            n_err++; $display("FAIL reset_ex_fields: got pc=%h imm=%h rd=%0d op=%h want all 0", exPc, exImm, exRd, exOpcode);
        end
        n_cmp++; if (readRegister1 !== 5'd0) begin n_err++; $display("FAIL reset_nop_rs1: got %0d want 0", readRegister1); end

        reset     = 1'b0;
        readData1 = 32'h0000_0055;
        ifValid   = 1'b1;
        ifInstr   = I_ADDI_X5_7;
        ifPc      = 32'h0000_0100;
        tick();
        ifValid = 1'b0;
        tick();
        n_cmp++; if (exValid !== 1'b1) begin n_err++; $display("FAIL first_exValid: got %0h want 1", exValid); end
        n_cmp++; if (exRd !== 5'd5) begin n_err++; $display("FAIL first_exRd: got %0d want 5", exRd); end
        n_cmp++; if (exImm !== 32'd7) begin n_err++; $display("FAIL first_exImm: got %h want 00000007", exImm); end
        n_cmp++; if (exRegWrite !== 1'b1) begin n_err++; $display("FAIL first_exRegWrite: got %0h want 1", exRegWrite); end
        n_cmp++; if (exPc !== 32'h100) begin n_err++; $display("FAIL first_exPc: got %h want 00000100", exPc); end
        n_cmp++; if (exRs1Data !== 32'd0) begin n_err++; $display("FAIL first_x0_operand: got %h want 0", exRs1Data); end
        tick();
        n_cmp++; if (exValid !== 1'b0) begin n_err++; $display("FAIL first_drain: got %0h want 0", exValid); end
    endtask

    task automatic test_load_use();
        readData1 = 32'h0000_0011;
        readData2 = 32'h0000_0022;
        ifValid = 1'b1; ifInstr = I_LW_X6; ifPc = 32'h200;
        tick();
        ifInstr = I_ADD_X7; ifPc = 32'h204;
        tick();
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall_on: got %0h want 1", stall); end
        n_cmp++; if (exMemRead !== 1'b1 || exRd !== 5'd6 || exFunct3 !== 3'd2) begin
            n_err++; $display("FAIL lu_load_in_ex: got memRead=%0h rd=%0d f3=%0d want 1/6/2", exMemRead, exRd, exFunct3);
        end
        n_cmp++; if (readRegister1 !== 5'd6) begin n_err++; $display("FAIL lu_readRegister1: got %0d want 6", readRegister1); end
        tick();
        n_cmp++; if (exValid !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got %0h want 0", exValid); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_once: got %0h want 0", stall); end
        ifValid = 1'b0;
        tick();
        n_cmp++; if (exValid !== 1'b1 || exRs1 !== 5'd6 || exRs2 !== 5'd1 || exRd !== 5'd7) begin
            n_err++; $display("FAIL lu_add_in_ex: got v=%0h rs1=%0d rs2=%0d rd=%0d want 1/6/1/7", exValid, exRs1, exRs2, exRd);
        end
        n_cmp++; if (exPc !== 32'h204) begin n_err++; $display("FAIL lu_add_pc: got %h want 00000204", exPc); end
        n_cmp++; if (exRs1Data !== 32'h11 || exRs2Data !== 32'h22) begin
            n_err++; $display("FAIL lu_add_operands: got %h/%h want 00000011/00000022", exRs1Data, exRs2Data);
        end
        n_cmp++; if (exImm !== 32'd0 || exMemRead !== 1'b0) begin
            n_err++; $display("FAIL lu_add_imm: got imm=%h memRead=%0h want 0/0", exImm, exMemRead);
        end
        tick();
    endtask

    task automatic test_forwarding();
        logic [4:0]  wb_rd_tab [3] = '{5'd3, 5'd0, 5'd5};
        logic [31:0] rd1_tab   [3] = '{32'h0, 32'h0, 32'h0000_A5A5};
        logic [31:0] exp_tab   [3] = '{32'hDEAD_BEEF, 32'h0, 32'h0000_A5A5};
        for (int i = 0; i < 3; i++) begin
            ifValid = 1'b1; ifInstr = I_SUB_X4; ifPc = 32'h300 + 32'(i * 4);
            tick();
            ifValid    = 1'b0;
            wbRegWrite = 1'b1;
            wbRd       = wb_rd_tab[i];
            wbData     = 32'hDEAD_BEEF;
            readData1  = rd1_tab[i];
            readData2  = rd1_tab[i];
            tick();
            wbRegWrite = 1'b0;
            n_cmp++; if (exRs1Data !== exp_tab[i] || exRs2Data !== exp_tab[i]) begin
                n_err++; $display("FAIL fwd_case%0d: got %h/%h want %h", i, exRs1Data, exRs2Data, exp_tab[i]);
            end
            n_cmp++; if (exFunct7b5 !== 1'b1 || exRd !== 5'd4) begin
                n_err++; $display("FAIL fwd_sub_fields%0d: got f7b5=%0h rd=%0d want 1/4", i, exFunct7b5, exRd);
            end
        end
    endtask

    task automatic test_immediates();
        logic [31:0] instr_tab [5] = '{32'hFE00_0EE3, 32'h1234_50B7, 32'hFE20_AFA3, 32'h0010_00EF, 32'hFFF0_0093};
        logic [31:0] imm_tab   [5] = '{32'hFFFF_FFFC, 32'h1234_5000, 32'hFFFF_FFFF, 32'h0000_0800, 32'hFFFF_FFFF};
        string       name_tab  [5] = '{"beq_m4", "lui", "sw_m1", "jal_2048", "addi_m1"};
        for (int i = 0; i < 5; i++) begin
            ifValid = 1'b1; ifInstr = instr_tab[i]; ifPc = 32'h400;
            tick();
            ifValid = 1'b0;
            tick();
            n_cmp++; if (exImm !== imm_tab[i]) begin
                n_err++; $display("FAIL imm_%s: got %h want %h", name_tab[i], exImm, imm_tab[i]);
            end
        end
    endtask

    task automatic test_flush_stall();
        ifValid = 1'b1; ifInstr = I_LW_X6; ifPc = 32'h500;
        tick();
        ifInstr = I_ADD_X7; ifPc = 32'h504;
        tick();
        flush = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL flush_stall_comb: got %0h want 1", stall); end
        tick();
        flush = 1'b0; ifValid = 1'b0;
        n_cmp++; if (exValid !== 1'b0 || stall !== 1'b0) begin
            n_err++; $display("FAIL flush_bubble: got v=%0h stall=%0h want 0/0", exValid, stall);
        end
        tick();
        n_cmp++; if (exValid !== 1'b0) begin n_err++; $display("FAIL flush_ifid_killed: got %0h want 0", exValid); end
    endtask

    task automatic test_reset_mid_stall();
        ifValid = 1'b1; ifInstr = I_LW_X6; ifPc = 32'h600;
        tick();
        ifInstr = I_ADD_X7; ifPc = 32'h604;
        tick();
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_stall_setup: got %0h want 1", stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0; ifValid = 1'b0;
        n_cmp++; if (exValid !== 1'b0 || stall !== 1'b0 || exMemRead !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_stall: got v=%0h stall=%0h mr=%0h want 0/0/0", exValid, stall, exMemRead);
        end
        tick();
        n_cmp++; if (exValid !== 1'b0) begin n_err++; $display("FAIL rst_discard_held: got %0h want 0", exValid); end
    endtask

    task automatic test_illegal_and_bubble();
        ifValid = 1'b1; ifInstr = 32'h0000_037F; ifPc = 32'h700;
        tick();
        ifInstr = 32'h0050_0013; ifPc = 32'h704;
        tick();
        n_cmp++; if (exIllegal !== 1'b1 || exRegWrite !== 1'b0 || exMemRead !== 1'b0 || exValid !== 1'b1) begin
            n_err++; $display("FAIL illegal_op: got ill=%0h rw=%0h mr=%0h v=%0h want 1/0/0/1", exIllegal, exRegWrite, exMemRead, exValid);
        end
        ifInstr = I_LW_X6; ifPc = 32'h708;
        tick();
        n_cmp++; if (exRegWrite !== 1'b0 || exValid !== 1'b1 || exIllegal !== 1'b0) begin
            n_err++; $display("FAIL addi_x0: got rw=%0h v=%0h ill=%0h want 0/1/0", exRegWrite, exValid, exIllegal);
        end
        ifValid = 1'b0; ifInstr = I_ADD_X7; ifPc = 32'h70C;
        tick();
        n_cmp++; if (stall !== 1'b0 || exMemRead !== 1'b1) begin
            n_err++; $display("FAIL invalid_no_stall: got stall=%0h mr=%0h want 0/1", stall, exMemRead);
        end
        tick();
        n_cmp++; if (exValid !== 1'b0) begin n_err++; $display("FAIL invalid_bubble: got %0h want 0", exValid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr_tab [3] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
        for (int i = 0; i < 3; i++) begin
            ifValid = 1'b1; ifInstr = instr_tab[i]; ifPc = 32'h800 + 32'(i * 4);
            tick();
            if (i > 0) begin
                n_cmp++; if (exRd !== 5'(i) || exImm !== 32'(i) || exPc !== 32'h800 + 32'((i - 1) * 4)) begin
                    n_err++; $display("FAIL b2b_%0d: got rd=%0d imm=%h pc=%h want %0d", i, exRd, exImm, exPc, i);
                end
            end
        end
        ifValid = 1'b0;
        tick();
        n_cmp++; if (exRd !== 5'd3 || exImm !== 32'd3 || exValid !== 1'b1) begin
            n_err++; $display("FAIL b2b_3: got rd=%0d imm=%h v=%0h want 3/3/1", exRd, exImm, exValid);
        end
        tick();
        n_cmp++; if (exValid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %0h want 0", exValid); end
    endtask

    initial begin
        reset      = 1'b1;
        ifValid    = 1'b0;
        ifInstr    = 32'h0;
        ifPc       = '0;
        flush      = 1'b0;
        readData1  = '0;
        readData2  = '0;
        wbRegWrite = 1'b0;
        wbRd       = 5'd0;
        wbData     = '0;

        test_reset();
        test_load_use();
        test_forwarding();
        test_immediates();
        test_flush_stall();
        test_reset_mid_stall();
        test_illegal_and_bubble();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
